// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bus between the load/store front-end and a data SRAM with
// variable latency (req / addr_ok / data_ok handshake).
//
// Signals:
//   bus_req      request valid (master -> slave)
//   bus_wr       1 = write
//   bus_wstrb    byte-lane enables, DATA_WIDTH/8 bits
//   bus_addr     masked byte address
//   bus_wdata    lane-steered write data
//   bus_addr_ok  request accepted (slave -> master)
//   bus_data_ok  read data / write ack valid
//   bus_rdata    read data
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                      bus_req;
   logic                      bus_wr;
   logic [DATA_WIDTH/8-1:0]   bus_wstrb;
   logic [ADDR_WIDTH-1:0]     bus_addr;
   logic [DATA_WIDTH-1:0]     bus_wdata;
   logic                      bus_addr_ok;
   logic                      bus_data_ok;
   logic [DATA_WIDTH-1:0]     bus_rdata;

   modport master (
      output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   modport slave (
      input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Load/store front-end between the MEM pipeline stage and a variable-latency
// data SRAM bus. Checks alignment, registers the request, stalls the pipeline
// until the bus responds and holds the extended load result until the stage
// advances.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   -> bus watchdog; after TIMEOUT_CYCLES in ADDR/DATA the FSM
//                forces DONE with dout=0 and exception=1.
//   undefined -> the FSM waits on the bus indefinitely.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   addr_i             byte address (held by the pipeline while stalled)
//   din_i              store data, right-aligned
//   mem_write_i        store request
//   mem_read_i         load request
//   mem_size_i         00 byte, 01 half, 10 word, 11 double
//   mem_sign_i         sign-extend load result
//   pipe_advance_i     MEM stage result consumed this cycle
//   dout_o             extended load data
//   require_stall_o    hold pipeline
//   exception_o        alignment/size error, or bus timeout
//   mem_bus            data_mem_ctrl_if.master bus port
//
// States:
//   state   | meaning
//   S_IDLE  | no transaction; evaluate new access, flag misaligned ones
//   S_ADDR  | bus_req high, waiting for addr_ok (and maybe data_ok)
//   S_DATA  | request accepted, waiting for data_ok
//   S_DONE  | result valid on dout_o, waiting for pipe_advance_i
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_MASK      = 32'h1FFF_FFFF,
   parameter int                    TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  mem_write_i,
   input  logic                  mem_read_i,
   input  logic [1:0]            mem_size_i,
   input  logic                  mem_sign_i,
   input  logic                  pipe_advance_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  require_stall_o,
   output logic                  exception_o,
   data_mem_ctrl_if.master       mem_bus
);

   localparam int NB  = DATA_WIDTH / 8;
   localparam int OFF = $clog2(NB);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state_q;
   logic                    req_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    wr_q;
   logic [NB-1:0]           wstrb_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [1:0]              size_q;
   logic                    sign_q;
   logic [OFF-1:0]          lane_q;
   logic [DATA_WIDTH-1:0]   dout_q;

   logic                    access;
   logic                    misalign;
   logic                    exc_align;
   logic                    start;
   logic                    busy;
   logic                    done_now;
   logic                    tmo_hit;
   logic                    tmo_q;
   logic [OFF-1:0]          lane_d;
   logic [NB-1:0]           size_mask;
   logic [NB-1:0]           wstrb_d;
   logic [DATA_WIDTH-1:0]   wdata_d;

   // Shift the raw bus word down to the addressed lane, keep the access size
   // and fill the upper bits with zero or the sign bit of that size.
   function automatic logic [DATA_WIDTH-1:0] extend(
      input logic [DATA_WIDTH-1:0] raw,
      input logic [OFF-1:0]        lane,
      input logic [1:0]            size,
      input logic                  sgn
   );
      logic [DATA_WIDTH-1:0] s;
      logic [DATA_WIDTH-1:0] r;
      int                    nb;
      logic                  fill;
      s = raw >> {lane, 3'b000};
      case (size)
         2'b00:   begin nb = 8;          fill = sgn & s[7];            end
         2'b01:   begin nb = 16;         fill = sgn & s[15];           end
         2'b10:   begin nb = 32;         fill = sgn & s[31];           end
         default: begin nb = DATA_WIDTH; fill = sgn & s[DATA_WIDTH-1]; end
      endcase
      r = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         r[i] = (i < nb) ? s[i] : fill;
      end
      return r;
   endfunction

   assign access = mem_read_i | mem_write_i;
   assign lane_d = addr_i[OFF-1:0];

   always_comb begin
      misalign = 1'b0;
      case (mem_size_i)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = addr_i[0];
         2'b10:   misalign = |addr_i[1:0];
         default: misalign = (DATA_WIDTH == 32) || (|addr_i[2:0]);
      endcase
   end

   assign exc_align = access & ((mem_read_i & mem_write_i) | misalign);
   assign start     = (state_q == S_IDLE) & access & ~exc_align;
   assign busy      = (state_q == S_ADDR) | (state_q == S_DATA);
   assign done_now  = ((state_q == S_ADDR) & mem_bus.bus_addr_ok & mem_bus.bus_data_ok) |
                      ((state_q == S_DATA) & mem_bus.bus_data_ok);

   // Write lanes and replicated write data; an aligned access never carries
   // mask bits past the top lane, so the shift cannot lose enables.
   always_comb begin
      size_mask = '0;
      case (mem_size_i)
         2'b00:   size_mask[0]   = 1'b1;
         2'b01:   size_mask[1:0] = 2'b11;
         2'b10:   size_mask[3:0] = 4'b1111;
         default: size_mask      = '1;
      endcase
      wstrb_d = mem_write_i ? (size_mask << lane_d) : '0;
      wdata_d = '0;
      if (mem_write_i) begin
         case (mem_size_i)
            2'b00:   wdata_d = {NB{din_i[7:0]}};
            2'b01:   wdata_d = {(NB/2){din_i[15:0]}};
            2'b10:   wdata_d = {(DATA_WIDTH/32){din_i[31:0]}};
            default: wdata_d = din_i;
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_cnt_q;

   // Hit on the last allowed cycle so DONE is entered exactly
   // TIMEOUT_CYCLES cycles after the request went out.
   assign tmo_hit = busy & (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         if (start) begin
            tmo_cnt_q <= '0;
         end else if (busy) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
         if (tmo_hit & ~done_now) begin
            tmo_q <= 1'b1;
         end else if ((state_q == S_DONE) & pipe_advance_i) begin
            tmo_q <= 1'b0;
         end
      end
   end
`else
   logic unused_tmo_cfg;

   assign tmo_hit        = 1'b0;
   assign tmo_q          = 1'b0;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         lane_q  <= '0;
         dout_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Any data_ok seen here belongs to an aborted transaction.
               if (start) begin
                  addr_q  <= addr_i & ADDR_MASK;
                  wr_q    <= mem_write_i;
                  wstrb_q <= wstrb_d;
                  wdata_q <= wdata_d;
                  size_q  <= mem_size_i;
                  sign_q  <= mem_sign_i;
                  lane_q  <= lane_d;
                  req_q   <= 1'b1;
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (mem_bus.bus_addr_ok & mem_bus.bus_data_ok) begin
                  req_q   <= 1'b0;
                  dout_q  <= wr_q ? '0 : extend(mem_bus.bus_rdata, lane_q, size_q, sign_q);
                  state_q <= S_DONE;
               end else if (tmo_hit) begin
                  req_q   <= 1'b0;
                  dout_q  <= '0;
                  state_q <= S_DONE;
               end else if (mem_bus.bus_addr_ok) begin
                  req_q   <= 1'b0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (mem_bus.bus_data_ok) begin
                  dout_q  <= wr_q ? '0 : extend(mem_bus.bus_rdata, lane_q, size_q, sign_q);
                  state_q <= S_DONE;
               end else if (tmo_hit) begin
                  dout_q  <= '0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (pipe_advance_i) begin
                  dout_q  <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_bus.bus_req   = req_q;
   assign mem_bus.bus_wr    = wr_q;
   assign mem_bus.bus_wstrb = wstrb_q;
   assign mem_bus.bus_addr  = addr_q;
   assign mem_bus.bus_wdata = wdata_q;

   assign dout_o          = dout_q;
   assign require_stall_o = access & ~exc_align & (state_q != S_DONE);
   assign exception_o     = ((state_q == S_IDLE) & exc_align) | tmo_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 32-bit instance
   logic [31:0] a32, d32, o32;
   logic        wr32, rd32, sg32, adv32, st32, ex32;
   logic [1:0]  sz32;
   data_mem_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
   data_mem_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_MASK(32'h1FFF_FFFF), .TIMEOUT_CYCLES(8)
   ) u32 (
      .clk(clk), .rst_n(rst_n), .addr_i(a32), .din_i(d32), .mem_write_i(wr32),
      .mem_read_i(rd32), .mem_size_i(sz32), .mem_sign_i(sg32), .pipe_advance_i(adv32),
      .dout_o(o32), .require_stall_o(st32), .exception_o(ex32), .mem_bus(b32)
   );

   // 64-bit instance
   logic [31:0] a64;
   logic [63:0] d64, o64;
   logic        wr64, rd64, sg64, adv64, st64, ex64;
   logic [1:0]  sz64;
   data_mem_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();
   data_mem_ctrl #(
      .DATA_WIDTH(64), .ADDR_WIDTH(32), .ADDR_MASK(32'h1FFF_FFFF), .TIMEOUT_CYCLES(8)
   ) u64 (
      .clk(clk), .rst_n(rst_n), .addr_i(a64), .din_i(d64), .mem_write_i(wr64),
      .mem_read_i(rd64), .mem_size_i(sz64), .mem_sign_i(sg64), .pipe_advance_i(adv64),
      .dout_o(o64), .require_stall_o(st64), .exception_o(ex64), .mem_bus(b64)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait transaction on the 32-bit instance; returns what the bus saw
   // in ADDR and the result/stall in DONE, then advances back to IDLE.
   task automatic zw32(input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input logic [1:0] sz, input logic sg, input logic [31:0] rdata,
                       output logic [31:0] baddr, output logic [3:0] bstrb,
                       output logic [31:0] bwdata, output logic [31:0] dout,
                       output logic stall_done);
      a32 = a; d32 = d; wr32 = wr; rd32 = ~wr; sz32 = sz; sg32 = sg;
      b32.bus_addr_ok = 1'b1; b32.bus_data_ok = 1'b1; b32.bus_rdata = rdata;
      step();
      baddr = b32.bus_addr; bstrb = b32.bus_wstrb; bwdata = b32.bus_wdata;
      step();
      dout = o32; stall_done = st32;
      adv32 = 1'b1; rd32 = 1'b0; wr32 = 1'b0;
      b32.bus_addr_ok = 1'b0; b32.bus_data_ok = 1'b0;
      step();
      adv32 = 1'b0;
   endtask

   task automatic zw64(input logic [31:0] a, input logic [63:0] d, input logic wr,
                       input logic [1:0] sz, input logic sg, input logic [63:0] rdata,
                       output logic [31:0] baddr, output logic [7:0] bstrb,
                       output logic [63:0] bwdata, output logic [63:0] dout);
      a64 = a; d64 = d; wr64 = wr; rd64 = ~wr; sz64 = sz; sg64 = sg;
      b64.bus_addr_ok = 1'b1; b64.bus_data_ok = 1'b1; b64.bus_rdata = rdata;
      step();
      baddr = b64.bus_addr; bstrb = b64.bus_wstrb; bwdata = b64.bus_wdata;
      step();
      dout = o64;
      adv64 = 1'b1; rd64 = 1'b0; wr64 = 1'b0;
      b64.bus_addr_ok = 1'b0; b64.bus_data_ok = 1'b0;
      step();
      adv64 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ba, bw, dq;
      logic [3:0]  bs;
      logic [63:0] bw64, dq64;
      logic [7:0]  bs64;
      logic        sd;
      int          req_cnt, stall_cnt, n;

      rst_n = 1'b0;
      a32 = '0; d32 = '0; wr32 = 0; rd32 = 0; sg32 = 0; adv32 = 0; sz32 = '0;
      a64 = '0; d64 = '0; wr64 = 0; rd64 = 0; sg64 = 0; adv64 = 0; sz64 = '0;
      b32.bus_addr_ok = 0; b32.bus_data_ok = 0; b32.bus_rdata = '0;
      b64.bus_addr_ok = 0; b64.bus_data_ok = 0; b64.bus_rdata = '0;
      #12;
      chk("rst_dout", 64'(o32), 64'h0);
      chk("rst_stall", 64'(st32), 64'h0);
      chk("rst_exc", 64'(ex32), 64'h0);
      chk("rst_req", 64'(b32.bus_req), 64'h0);
      chk("rst_addr", 64'(b32.bus_addr), 64'h0);
      chk("rst_wstrb", 64'(b32.bus_wstrb), 64'h0);
      chk("rst_wdata64", b64.bus_wdata, 64'h0);
      rst_n = 1'b1;
      step();

      // Word load, zero-wait slave; data_ok already high while still IDLE
      a32 = 32'h0000_0104; rd32 = 1'b1; sz32 = 2'b10; sg32 = 1'b0;
      b32.bus_addr_ok = 1'b1; b32.bus_data_ok = 1'b1; b32.bus_rdata = 32'hDEAD_BEEF;
      #1;
      chk("wl_T_stall", 64'(st32), 64'h1);
      chk("wl_T_exc", 64'(ex32), 64'h0);
      chk("wl_T_req", 64'(b32.bus_req), 64'h0);
      step();
      chk("wl_T1_req", 64'(b32.bus_req), 64'h1);
      chk("wl_T1_addr", 64'(b32.bus_addr), 64'h0000_0104);
      chk("wl_T1_wstrb", 64'(b32.bus_wstrb), 64'h0);
      chk("wl_T1_wr", 64'(b32.bus_wr), 64'h0);
      chk("wl_T1_dout", 64'(o32), 64'h0);
      chk("wl_T1_stall", 64'(st32), 64'h1);
      step();
      chk("wl_T2_stall", 64'(st32), 64'h0);
      chk("wl_T2_dout", 64'(o32), 64'hDEAD_BEEF);
      chk("wl_T2_req", 64'(b32.bus_req), 64'h0);
      // Hold in DONE without advance: result stays stable
      b32.bus_rdata = 32'h1111_1111;
      step();
      chk("wl_hold_dout", 64'(o32), 64'hDEAD_BEEF);
      chk("wl_hold_stall", 64'(st32), 64'h0);
      adv32 = 1'b1; rd32 = 1'b0; b32.bus_addr_ok = 0; b32.bus_data_ok = 0;
      step();
      adv32 = 1'b0;
      chk("wl_idle_dout", 64'(o32), 64'h0);

      // Signed / unsigned byte loads through kseg mask
      zw32(32'h8000_0003, 32'h0, 1'b0, 2'b00, 1'b1, 32'h80FF_0000, ba, bs, bw, dq, sd);
      chk("sb_addr", 64'(ba), 64'h0000_0003);
      chk("sb_dout", 64'(dq), 64'hFFFF_FF80);
      chk("sb_stall", 64'(sd), 64'h0);
      zw32(32'h8000_0003, 32'h0, 1'b0, 2'b00, 1'b0, 32'h80FF_0000, ba, bs, bw, dq, sd);
      chk("ub_dout", 64'(dq), 64'h0000_0080);
      // Signed half load, lane 2
      zw32(32'h0000_0042, 32'h0, 1'b0, 2'b01, 1'b1, 32'h9ABC_0000, ba, bs, bw, dq, sd);
      chk("sh_dout", 64'(dq), 64'hFFFF_9ABC);
      // Byte store lane 1
      zw32(32'h0000_2001, 32'h1234_56A5, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, ba, bs, bw, dq, sd);
      chk("bs_wstrb", 64'(bs), 64'h2);
      chk("bs_wdata", 64'(bw), 64'hA5A5_A5A5);
      chk("bs_dout", 64'(dq), 64'h0);

      // Half store with addr_ok after 3 waits and data_ok 2 cycles later
      a32 = 32'h0000_1002; d32 = 32'hABCD_1234; wr32 = 1'b1; rd32 = 1'b0; sz32 = 2'b01;
      #1;
      chk("hs_T_stall", 64'(st32), 64'h1);
      req_cnt = 0; stall_cnt = 0; bs = '0; bw = '0;
      for (int i = 1; i <= 6; i++) begin
         step();
         b32.bus_addr_ok = (i == 4);
         b32.bus_data_ok = (i == 6);
         #1;
         req_cnt   += int'(b32.bus_req);
         stall_cnt += int'(st32);
         if (i == 1) begin
            bs = b32.bus_wstrb;
            bw = b32.bus_wdata;
         end
      end
      step();
      b32.bus_addr_ok = 1'b0; b32.bus_data_ok = 1'b0;
      #1;
      chk("hs_req_cycles", 64'(req_cnt), 64'd4);
      chk("hs_stall_cycles", 64'(stall_cnt), 64'd6);
      chk("hs_wstrb", 64'(bs), 64'hC);
      chk("hs_wdata", 64'(bw), 64'h1234_1234);
      chk("hs_done_stall", 64'(st32), 64'h0);
      chk("hs_done_dout", 64'(o32), 64'h0);
      adv32 = 1'b1; wr32 = 1'b0;
      step();
      adv32 = 1'b0;

      // Misaligned / illegal accesses
      a32 = 32'h0000_0106; rd32 = 1'b1; sz32 = 2'b10;
      #1;
      chk("mis_w_exc", 64'(ex32), 64'h1);
      chk("mis_w_stall", 64'(st32), 64'h0);
      step();
      chk("mis_w_req", 64'(b32.bus_req), 64'h0);
      a32 = 32'h0000_0100; rd32 = 1'b1; wr32 = 1'b1;
      #1;
      chk("rw_exc", 64'(ex32), 64'h1);
      chk("rw_stall", 64'(st32), 64'h0);
      wr32 = 1'b0; a32 = 32'h0000_0008; sz32 = 2'b11;
      #1;
      chk("dbl32_exc", 64'(ex32), 64'h1);
      a32 = 32'h0000_0101; sz32 = 2'b01;
      #1;
      chk("mis_h_exc", 64'(ex32), 64'h1);
      a32 = 32'h0000_0102;
      #1;
      chk("ok_h_exc", 64'(ex32), 64'h0);
      chk("ok_h_stall", 64'(st32), 64'h1);
      rd32 = 1'b0;
      #1;
      chk("noacc_exc", 64'(ex32), 64'h0);
      step();
      chk("mis_idle_req", 64'(b32.bus_req), 64'h0);

      // 64-bit instance
      zw64(32'h0000_0008, 64'h0, 1'b0, 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF, ba, bs64, bw64, dq64);
      chk("d64_addr", 64'(ba), 64'h8);
      chk("d64_wstrb", 64'(bs64), 64'h0);
      chk("d64_dout", dq64, 64'h0123_4567_89AB_CDEF);
      zw64(32'h0000_0004, 64'h0, 1'b0, 2'b10, 1'b1, 64'h8765_4321_0000_0000, ba, bs64, bw64, dq64);
      chk("sw64_dout", dq64, 64'hFFFF_FFFF_8765_4321);
      zw64(32'h0000_0005, 64'h0000_0000_0000_005A, 1'b1, 2'b00, 1'b0, 64'h0, ba, bs64, bw64, dq64);
      chk("bs64_wstrb", 64'(bs64), 64'h20);
      chk("bs64_wdata", bw64, 64'h5A5A_5A5A_5A5A_5A5A);
      zw64(32'h0000_000C, 64'hFFFF_0000_1122_3344, 1'b1, 2'b10, 1'b0, 64'h0, ba, bs64, bw64, dq64);
      chk("ws64_wstrb", 64'(bs64), 64'hF0);
      chk("ws64_wdata", bw64, 64'h1122_3344_1122_3344);
      a64 = 32'h0000_0004; rd64 = 1'b1; sz64 = 2'b11;
      #1;
      chk("d64_mis_exc", 64'(ex64), 64'h1);
      chk("d64_mis_stall", 64'(st64), 64'h0);
      rd64 = 1'b0;
      step();
      chk("d64_mis_req", 64'(b64.bus_req), 64'h0);

      // Asynchronous reset while in DATA, late data_ok afterwards
      a32 = 32'h0000_0200; rd32 = 1'b1; sz32 = 2'b10; sg32 = 1'b0;
      step();
      b32.bus_addr_ok = 1'b1;
      step();
      b32.bus_addr_ok = 1'b0;
      #1;
      chk("rd_data_req", 64'(b32.bus_req), 64'h0);
      chk("rd_data_stall", 64'(st32), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("rd_rst_req", 64'(b32.bus_req), 64'h0);
      rd32 = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      b32.bus_data_ok = 1'b1; b32.bus_rdata = 32'hCAFE_F00D;
      step();
      b32.bus_data_ok = 1'b0;
      #1;
      chk("rd_late_dout", 64'(o32), 64'h0);
      rd32 = 1'b1;
      #1;
      chk("rd_idle_stall", 64'(st32), 64'h1);
      chk("rd_idle_req", 64'(b32.bus_req), 64'h0);
      b32.bus_addr_ok = 1'b1; b32.bus_data_ok = 1'b1; b32.bus_rdata = 32'h0BAD_CAFE;
      step();
      chk("rd_new_req", 64'(b32.bus_req), 64'h1);
      step();
      chk("rd_new_dout", 64'(o32), 64'h0BAD_CAFE);
      adv32 = 1'b1; rd32 = 1'b0; b32.bus_addr_ok = 0; b32.bus_data_ok = 0;
      step();
      adv32 = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // Slave never answers: watchdog forces DONE after 8 cycles in ADDR
      a32 = 32'h0000_0300; rd32 = 1'b1; sz32 = 2'b10;
      n = 0; req_cnt = 0;
      while (!ex32 && n < 20) begin
         step();
         n++;
         req_cnt += int'(b32.bus_req);
      end
      chk("tmo_cycles", 64'(n), 64'd9);
      chk("tmo_req_cycles", 64'(req_cnt), 64'd8);
      chk("tmo_exc", 64'(ex32), 64'h1);
      chk("tmo_dout", 64'(o32), 64'h0);
      chk("tmo_stall", 64'(st32), 64'h0);
      step();
      chk("tmo_exc_hold", 64'(ex32), 64'h1);
      adv32 = 1'b1; rd32 = 1'b0;
      step();
      adv32 = 1'b0;
      chk("tmo_exc_clear", 64'(ex32), 64'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised load/store front-end between the MEM pipeline stage and a variable-latency data SRAM bus using a req/addr_ok/data_ok handshake.
- Generalises the fixed single-cycle data memory port:
  - DATA_WIDTH of 32 or 64, with doubleword access at 64.
  - Registered request phase and FSM-driven stall until the bus responds.
  - Result held stable until the pipeline advances.

Parameters:
- DATA_WIDTH, 32, bus/data width; legal values 32 or 64.
- ADDR_WIDTH, 32, address width.
- ADDR_MASK, 32'h1FFF_FFFF, AND-mask applied to addr before driving the bus (kseg translation).
- TIMEOUT_CYCLES, 256, bus watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- addr  in  ADDR_WIDTH  byte address; held stable by the pipeline while require_stall=1.
- din  in  DATA_WIDTH  store data, right-aligned.
- mem_write  in  1  store request.
- mem_read  in  1  load request.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 double.
- mem_sign  in  1  sign-extend load result.
- pipe_advance  in  1  MEM stage result consumed this cycle.
- dout  out  DATA_WIDTH  extended load data.
- require_stall  out  1  hold pipeline.
- exception  out  1  address/size error, or bus timeout.
- bus_req  out  1  request valid.
- bus_wr  out  1  1 = write.
- bus_wstrb  out  DATA_WIDTH/8  byte-lane enables.
- bus_addr  out  ADDR_WIDTH  masked address.
- bus_wdata  out  DATA_WIDTH  lane-steered write data.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  read data or write ack valid.
- bus_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Terms:
  - access = mem_read | mem_write.
  - OFF = log2(DATA_WIDTH/8) low address bits.
  - lane = addr[OFF-1:0].
- exception (combinational, IDLE state), asserted when access=1 and any of:
  - mem_read & mem_write both high.
  - Half with addr[0]≠0.
  - Word with addr[1:0]≠0.
  - Double with DATA_WIDTH=32.
  - Double with addr[2:0]≠0.
- An excepting access issues no bus request and causes no stall.
- FSM states: IDLE, ADDR, DATA, DONE. Reset state is IDLE.
- IDLE:
  - On access & !exception, capture the request registers (addr&ADDR_MASK, wr, wstrb, wdata, size, sign, lane) and go to ADDR.
  - Otherwise stay.
  - bus_data_ok received in IDLE is ignored.
- ADDR:
  - bus_req=1, all bus_* outputs driven from the captured registers.
  - addr_ok & data_ok: go to DONE.
  - addr_ok only: go to DATA.
  - Neither: stay.
- DATA:
  - bus_req=0.
  - On data_ok, latch bus_rdata (loads) and go to DONE.
- DONE:
  - dout = extension of the latched data.
  - On pipe_advance, go to IDLE.
  - A new access is evaluated the cycle after returning to IDLE, never in DONE.
- require_stall = access & !exception & (state≠DONE).
- Minimum latency (zero-wait slave): access seen at T, bus_req at T+1, addr_ok+data_ok at T+1, DONE at T+2 with require_stall=0.
- bus_wstrb (bus_wr=1) = size mask shifted left by lane:
  - Byte 1 bit, half 2 bits, word 4 bits, double 8 bits.
  - Reads drive bus_wstrb = 0.
- bus_wdata:
  - Byte: din[7:0] replicated to every lane.
  - Half: din[15:0] replicated.
  - Word: din[31:0] replicated.
  - Double: din.
  - No X values are driven.
- Load extraction: right-shift the latched data by lane*8, take the low 8/16/32/64 bits, then zero- or sign-extend per the captured sign.
- dout = 0 in IDLE, ADDR, DATA, and for stores.
- Reset values: all outputs 0 and all registers 0.
- Asynchronous reset mid-transaction:
  - Immediately returns the FSM to IDLE and drops bus_req.
  - Any late data_ok is ignored.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter clears on entering ADDR and increments each cycle in ADDR or DATA.
  - On reaching TIMEOUT_CYCLES, the FSM forces DONE with dout=0 and exception=1 held in DONE until pipe_advance.
  - Counter is 0 on reset.
- Undefined: no counter; the FSM waits indefinitely, and exception reflects only the alignment checks.

Test Plan:
- Word load at 0x0000_0104, zero-wait slave returning 0xDEAD_BEEF → require_stall high for cycles T and T+1, dout=0xDEAD_BEEF at T+2, bus_addr=0x0000_0104.
- Signed byte load at addr 0x8000_0003, rdata 0x80FF_0000 → bus_addr 0x0000_0003, dout 0xFFFF_FF80; the same load unsigned → 0x0000_0080.
- Half store at addr ...02, din 0x1234, with addr_ok delayed 3 cycles and data_ok delayed 2 more → bus_req high exactly 4 cycles, wstrb 4'b1100, wdata 0x1234_1234, stall released on the cycle after data_ok.
- Word load at addr ...06 → exception=1 in the same cycle, bus_req never asserted, require_stall=0; mem_read & mem_write together → exception=1.
- DATA_WIDTH=64, double load at ...08 → wstrb 0, full 64-bit dout; double load at ...04 → exception. With DATA_WIDTH=32, any double access → exception.
- rst_n pulsed low while in DATA, then data_ok after release → FSM in IDLE, dout=0, no DONE. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that never sends addr_ok → DONE with exception=1 after 8 cycles.
